// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: capture/display request ports and SRAM pins of the SRAM port arbiter
interface sram_port_arbiter_if #(
  parameter int AW = 20,
  parameter int DW = 16,
  parameter int LW = 4
);
  logic          i_wr_valid;
  logic          o_wr_ready;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          i_rd_valid;
  logic          o_rd_ready;
  logic [AW-1:0] i_rd_addr;
  logic          o_rd_rvalid;
  logic [DW-1:0] o_rd_rdata;
  logic [AW-1:0] o_s_addr;
  logic [DW-1:0] o_s_data;
  logic          o_s_wen;
  logic [DW-1:0] i_s_data;
  logic [LW-1:0] o_wfifo_level;
  modport slave (
    input  i_wr_valid, i_wr_addr, i_wr_data, i_rd_valid, i_rd_addr, i_s_data,
    output o_wr_ready, o_rd_ready, o_rd_rvalid, o_rd_rdata, o_s_addr, o_s_data, o_s_wen, o_wfifo_level
  );
  modport master (
    output i_wr_valid, i_wr_addr, i_wr_data, i_rd_valid, i_rd_addr, i_s_data,
    input  o_wr_ready, o_rd_ready, o_rd_rvalid, o_rd_rdata, o_s_addr, o_s_data, o_s_wen, o_wfifo_level
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares a single-port SRAM between a FIFO-buffered capture writer and a priority display reader
module sram_port_arbiter #(
  parameter int AW           = 20,
  parameter int DW           = 16,
  parameter int WFIFO_DEPTH  = 8,
  parameter int MAX_RD_BURST = 16,
  parameter int RD_LAT       = 1
) (
  input logic                i_clk,
  input logic                i_rst,
  sram_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(WFIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(MAX_RD_BURST + 1);
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_TURN} state_t;
  state_t            state_q, state_d;
  logic [AW-1:0]     fifo_addr_q [WFIFO_DEPTH];
  logic [DW-1:0]     fifo_data_q [WFIFO_DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]     s_addr_q, s_addr_d;
  logic [DW-1:0]     s_data_q, s_data_d, rdata_q;
  logic              s_wen_q;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic              empty, full, starve, rd_ready, push, pop;
  always_comb begin
    empty    = level_q == '0;
    full     = level_q == LW'(WFIFO_DEPTH);
    starve   = rd_cnt_q >= CW'(MAX_RD_BURST) && !empty;
    rd_ready = state_q != S_WR && !starve;
    state_d  = starve                               ? S_WR   :
               (bus.i_rd_valid && rd_ready)         ? S_RD   :
               (bus.i_rd_valid && state_q == S_WR)  ? S_TURN :
               !empty                               ? S_WR   : S_IDLE;
    pop      = state_d == S_WR;
    push     = bus.i_wr_valid && !full;
    level_d  = level_q + LW'(push) - LW'(pop);
    rd_cnt_d = (pop || empty) ? '0 :
               (state_d == S_RD && rd_cnt_q < CW'(MAX_RD_BURST)) ? rd_cnt_q + 1'b1 : rd_cnt_q;
    s_addr_d = pop ? fifo_addr_q[rptr_q] : (state_d == S_RD) ? bus.i_rd_addr : '0;
    s_data_d = pop ? fifo_data_q[rptr_q] : '0;
    // issue flag shifts one stage per cycle; the last stage marks the sample edge for i_s_data
    vld_d    = RD_LAT'({vld_q, state_q == S_RD});
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      rd_cnt_q <= '0;
      s_addr_q <= '0;
      s_data_q <= '0;
      s_wen_q  <= 1'b1;
      vld_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_q + PW'(push);
      rptr_q   <= rptr_q + PW'(pop);
      level_q  <= level_d;
      rd_cnt_q <= rd_cnt_d;
      s_addr_q <= s_addr_d;
      s_data_q <= s_data_d;
      s_wen_q  <= !pop;
      vld_q    <= vld_d;
      if (vld_d[RD_LAT-1]) rdata_q <= bus.i_s_data;
    end
  end
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= bus.i_wr_addr;
      fifo_data_q[wptr_q] <= bus.i_wr_data;
    end
  end
  assign bus.o_wr_ready    = !full;
  assign bus.o_rd_ready    = rd_ready;
  assign bus.o_rd_rvalid   = vld_q[RD_LAT-1];
  assign bus.o_rd_rdata    = rdata_q;
  assign bus.o_s_addr      = s_addr_q;
  assign bus.o_s_data      = s_data_q;
  assign bus.o_s_wen       = s_wen_q;
  assign bus.o_wfifo_level = level_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: queue-based reference model plus directed scenarios for the SRAM port arbiter
module tb_sram_port_arbiter;
  localparam int AW = 20, DW = 16, DEPTH = 8, MAXB = 16, RD_LAT = 1;
  localparam int LW = $clog2(DEPTH) + 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, errors = 0, cyc = 0, acc_cnt = 0;
  bit armed = 1'b0;
  sram_port_arbiter_if #(.AW(AW), .DW(DW), .LW(LW)) bus ();
  sram_port_arbiter #(.AW(AW), .DW(DW), .WFIFO_DEPTH(DEPTH), .MAX_RD_BURST(MAXB), .RD_LAT(RD_LAT)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  assign bus.i_s_data = bus.o_s_addr[DW-1:0] ^ 16'hA5A5;
  logic [AW+DW-1:0] wq[$];
  int               rq_due[$];
  logic [DW-1:0]    rq_dat[$];
  int               m_op, m_cnt;
  logic             m_wen, m_rv;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_data, m_rdata;
  logic [DW-1:0]    rv_log[$];
  int               rv_cyc[$];
  logic [AW+DW-1:0] wr_log[$];
  int               gap_log[$];
  logic [15:0]      exp_rd [4] = '{16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  task automatic model_step();
    int n, nop;
    bit stv, acc;
    logic [AW+DW-1:0] head;
    n = wq.size();
    head = '0;
    stv = m_cnt >= MAXB && n > 0;
    acc = bus.i_rd_valid && m_op != 2 && !stv;
    nop = stv ? 2 : acc ? 1 : (bus.i_rd_valid && m_op == 2) ? 3 : (n > 0) ? 2 : 0;
    if (nop == 2) head = wq.pop_front();
    if (bus.i_wr_valid && n < DEPTH) wq.push_back({bus.i_wr_addr, bus.i_wr_data});
    if (nop == 2 || n == 0) m_cnt = 0;
    else if (nop == 1 && m_cnt < MAXB) m_cnt++;
    if (acc) begin
      rq_due.push_back(cyc + RD_LAT);
      rq_dat.push_back(bus.i_rd_addr[DW-1:0] ^ 16'hA5A5);
    end
    m_op = nop;
    m_wen = nop != 2;
    m_addr = (nop == 2) ? head[AW+DW-1:DW] : (nop == 1) ? bus.i_rd_addr : '0;
    m_data = (nop == 2) ? head[DW-1:0] : '0;
    m_rv = rq_due.size() > 0 && rq_due[0] == cyc;
    if (m_rv) begin
      m_rdata = rq_dat.pop_front();
      void'(rq_due.pop_front());
    end
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      wq.delete(); rq_due.delete(); rq_dat.delete();
      m_op = 0; m_cnt = 0; m_wen = 1'b1; m_addr = '0; m_data = '0; m_rv = 1'b0; m_rdata = '0;
      armed = 1'b1;
    end else model_step();
  end
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("s_wen", bus.o_s_wen, m_wen);
      chk("s_addr", bus.o_s_addr, m_addr);
      chk("s_data", bus.o_s_data, m_data);
      chk("rvalid", bus.o_rd_rvalid, m_rv);
      if (m_rv) chk("rdata", bus.o_rd_rdata, m_rdata);
      chk("level", bus.o_wfifo_level, wq.size());
      chk("wr_ready", bus.o_wr_ready, wq.size() < DEPTH);
      chk("rd_ready", bus.o_rd_ready, m_op != 2 && !(m_cnt >= MAXB && wq.size() > 0));
      if (bus.o_rd_rvalid) begin rv_log.push_back(bus.o_rd_rdata); rv_cyc.push_back(cyc); end
      if (!bus.o_s_wen) begin
        wr_log.push_back({bus.o_s_addr, bus.o_s_data});
        gap_log.push_back(acc_cnt);
        acc_cnt = 0;
      end
      if (bus.i_rd_valid && bus.o_rd_ready) acc_cnt++;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog cyc %0d", cyc);
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    int n = 0;
    bus.i_wr_valid = 1'b1; bus.i_wr_addr = a; bus.i_wr_data = d;
    do begin ok = bus.o_wr_ready; step(); n++; end while (!ok && n < 50);
    if (!ok) begin checks++; errors++; $display("FAIL push_timeout addr %0h not accepted", a); end
    bus.i_wr_valid = 1'b0;
  endtask
  initial begin
    int e0, seen, idx;
    bit ok;
    logic [AW+DW-1:0] w;
    bus.i_wr_valid = 0; bus.i_wr_addr = '0; bus.i_wr_data = '0; bus.i_rd_valid = 0; bus.i_rd_addr = '0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wen", bus.o_s_wen, 1);
    chk("rst_addr", bus.o_s_addr, 0);
    chk("rst_level", bus.o_wfifo_level, 0);
    chk("rst_rvalid", bus.o_rd_rvalid, 0);
    rv_log.delete(); rv_cyc.delete();
    for (int a = 0; a < 4; a++) begin
      bus.i_rd_valid = 1'b1; bus.i_rd_addr = AW'(a);
      step();
      if (a == 0) e0 = cyc;
    end
    bus.i_rd_valid = 1'b0;
    repeat (4) step();
    chk("rd_count", rv_log.size(), 4);
    if (rv_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("rd_data", rv_log[i], exp_rd[i]);
      chk("rd_first_cyc", rv_cyc[0], e0 + 1);
      chk("rd_b2b", rv_cyc[3] - rv_cyc[0], 3);
    end
    wr_log.delete();
    for (int i = 0; i < 10; i++) push_word(AW'(32'h100 + i), DW'(32'h1000 + i));
    repeat (5) step();
    chk("wr_count", wr_log.size(), 10);
    if (wr_log.size() == 10)
      for (int i = 0; i < 10; i++) begin
        w = wr_log[i];
        chk("wr_addr", w[AW+DW-1:DW], 32'h100 + i);
        chk("wr_data", w[DW-1:0], 32'h1000 + i);
      end
    bus.i_wr_valid = 1'b1; bus.i_wr_addr = AW'(32'h200); bus.i_wr_data = 16'hBEEF;
    step();
    bus.i_wr_valid = 1'b0;
    step();
    bus.i_rd_valid = 1'b1; bus.i_rd_addr = AW'(32'h300);
    @(negedge clk);
    chk("wtr_wr_wen", bus.o_s_wen, 0);
    chk("wtr_wr_rdy", bus.o_rd_ready, 0);
    chk("wtr_wr_addr", bus.o_s_addr, 32'h200);
    chk("wtr_wr_data", bus.o_s_data, 32'hBEEF);
    step();
    @(negedge clk);
    chk("wtr_turn_wen", bus.o_s_wen, 1);
    chk("wtr_turn_rdy", bus.o_rd_ready, 1);
    step();
    bus.i_rd_valid = 1'b0;
    @(negedge clk);
    chk("wtr_rd_addr", bus.o_s_addr, 32'h300);
    chk("wtr_rd_wen", bus.o_s_wen, 1);
    repeat (3) step();
    acc_cnt = 0; gap_log.delete(); wr_log.delete();
    bus.i_rd_valid = 1'b1;
    for (int c = 0; c < 150 && wr_log.size() < 3; c++) begin
      bus.i_rd_addr = AW'(32'h600 + c);
      bus.i_wr_valid = c < 3; bus.i_wr_addr = AW'(32'h400 + c); bus.i_wr_data = DW'(32'h4000 + c);
      step();
    end
    bus.i_wr_valid = 1'b0;
    repeat (4) step();
    chk("stv_writes", wr_log.size(), 3);
    if (gap_log.size() == 3) begin
      chk("stv_gap1", gap_log[1], 16);
      chk("stv_gap2", gap_log[2], 16);
      w = wr_log[2];
      chk("stv_last_addr", w[AW+DW-1:DW], 32'h402);
    end
    bus.i_rd_valid = 1'b0;
    repeat (3) step();
    bus.i_rd_valid = 1'b1; bus.i_wr_valid = 1'b1;
    idx = 0; seen = 0;
    for (int c = 0; c < 60 && seen < 3; c++) begin
      bus.i_wr_addr = AW'(32'h500 + idx); bus.i_wr_data = DW'(32'h5000 + idx); bus.i_rd_addr = AW'(32'h800 + c);
      ok = bus.o_wr_ready;
      @(negedge clk);
      if (seen == 2) begin chk("full_repush_level", bus.o_wfifo_level, 8); seen = 3; end
      if (seen == 1) begin
        chk("full_pop_level", bus.o_wfifo_level, 7);
        chk("full_pop_wen", bus.o_s_wen, 0);
        chk("full_pop_ready", bus.o_wr_ready, 1);
        seen = 2;
      end
      if (seen == 0 && bus.o_wfifo_level == LW'(8) && !bus.o_rd_ready) seen = 1;
      step();
      if (ok) idx++;
    end
    chk("full_seen", seen, 3);
    bus.i_rd_valid = 1'b0; bus.i_wr_valid = 1'b0;
    for (int c = 0; c < 40 && bus.o_wfifo_level != '0; c++) step();
    @(negedge clk);
    chk("drain_level", bus.o_wfifo_level, 0);
    step();
    bus.i_rd_valid = 1'b1; bus.i_wr_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.i_rd_addr = AW'(32'h900 + c); bus.i_wr_addr = AW'(32'h700 + c); bus.i_wr_data = DW'(32'h7000 + c);
      step();
    end
    bus.i_wr_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_level", bus.o_wfifo_level, 5);
    rst = 1'b1;
    step();
    rst = 1'b0; bus.i_rd_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_level", bus.o_wfifo_level, 0);
    chk("mid_rst_rvalid", bus.o_rd_rvalid, 0);
    chk("mid_rst_wen", bus.o_s_wen, 1);
    chk("mid_rst_addr", bus.o_s_addr, 0);
    rv_log.delete(); wr_log.delete();
    repeat (4) step();
    chk("post_rst_rvalids", rv_log.size(), 0);
    chk("post_rst_writes", wr_log.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
